led_breathe: RTL and testbench
==============================

Name: led_breathe

Overview:
- PWM LED driver that sits directly downstream of the board clock divider; it consumes a one-cycle tick strobe rather than a derived clock.
- It produces a single LED output in one of four modes: off, solid, breathing (triangular brightness ramp with holds) or blink.
- It runs entirely in the 25 MHz clk_i domain.

Parameters:
- PWM_BITS, 8: width of the PWM counter and brightness level; MAX = 2^PWM_BITS-1.
- STEP, 1: brightness increment/decrement per tick in breathe mode; 1 <= STEP <= MAX.
- HOLD_TICKS, 16: ticks spent at the peak and at the trough in breathe mode; 0 means no hold.

Ports:
- clk_i  input  1  system clock (25 MHz on board).
- rst_ni  input  1  asynchronous, active-low reset.
- en_i  input  1  block enable.
- tick_i  input  1  single-cycle strobe from the upstream divider; advances brightness.
- mode_i  input  2  00 off, 01 solid, 10 breathe, 11 blink.
- led_o  output  1  registered PWM LED drive.
- level_o  output  PWM_BITS  current target brightness.
- peak_o  output  1  one-cycle pulse on reaching MAX in breathe mode.

Behaviour:
- Reset (async assert, sync release): pwm_cnt=0, duty=0, level_o=0, state=RAMP_UP, hold_cnt=0, mode_q=00, led_o=0, peak_o=0.
- PWM counter:
  - Free-running 0..MAX, wrapping MAX->0.
  - duty is loaded from level at the wrap edge only (pwm_cnt==MAX), so each period has constant duty (glitch-free).
  - led_o <= (pwm_cnt < duty), registered: 1 clk latency from counter to pin.
  - duty=0 gives constant 0; duty=MAX gives high MAX of every MAX+1 clocks.
- Mode handling: mode_q registers mode_i each cycle. Whenever mode_i != mode_q, next cycle: level=0, state=RAMP_UP, hold_cnt=0. Tick ignored that cycle.
- Mode 00 (off): level held at 0; led_o=0.
- Mode 01 (solid): led_o forced 1 (registered), bypassing PWM; level_o=MAX.
- Mode 10 (breathe), FSM states RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO; transitions occur only on a cycle with tick_i=1:
  - RAMP_UP: level += STEP, saturating at MAX. On reaching MAX -> HOLD_HI, pulse peak_o (same cycle level becomes MAX).
  - HOLD_HI: hold_cnt++. When hold_cnt == HOLD_TICKS-1, clear hold_cnt -> RAMP_DOWN. HOLD_TICKS=0 skips directly to RAMP_DOWN (HOLD_HI not entered).
  - RAMP_DOWN: level -= STEP, saturating at 0. On reaching 0 -> HOLD_LO.
  - HOLD_LO: symmetric to HOLD_HI, exiting to RAMP_UP.
  - Width rule: compute in PWM_BITS+1 bits and clamp; no wrap-around past MAX or below 0.
- Mode 11 (blink): each tick toggles level between 0 and MAX; FSM idle.
- en_i=0: pwm_cnt, level, FSM and hold_cnt frozen; led_o forced 0 next cycle; ticks ignored (not queued). On en_i=1, resume from the frozen state.
- tick_i is asserted for multiple consecutive cycles: each asserted cycle counts as one tick.
- Simultaneous events: tick and PWM wrap in the same cycle: duty loads the pre-tick level; the new level appears in the following period.
- Reset asserted mid-ramp: all state returns to reset values immediately (async); led_o low without waiting for a clock.
- peak_o: exactly one cycle wide; never asserted outside breathe mode.

Test Plan:
- PWM_BITS=4, mode 00->10 after reset, STEP=1, HOLD_TICKS=2, tick every 20 clks -> level_o 0,1,..,15; peak_o one pulse at level 15; held 2 ticks; then 14..0; held 2 ticks; then ramps up again.
- Force level 5 (breathe, stop ticks), PWM_BITS=4 -> led_o high exactly 5 of every 16 clks, starting 1 clk after pwm_cnt=0.
- Tick coincident with pwm_cnt==15 at level 5->6 -> current period 5 high clks, next period 6 high clks; no runt pulse.
- STEP=6, PWM_BITS=4, breathe -> level 0,6,12,15 (saturate), then 9,3,0; never wraps.
- Mode switch 10->11 mid-ramp at level 9 -> level 0 next cycle; subsequent ticks give 15,0,15; peak_o stays 0.
- en_i low for 100 clks at level 7 with 5 ticks -> led_o 0 throughout, level stays 7. Then rst_ni pulsed low mid-PWM-high -> led_o 0 asynchronously, level_o=0.

Source files
------------

// File: rtl/led_breathe.sv
// led_breathe: PWM LED driver with off / solid / breathe / blink modes.
// Brightness advances on a one-cycle tick strobe from the upstream divider.
// The PWM duty is reloaded only at the counter wrap, so every period is glitch-free.
module led_breathe #(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                tick_i,
  input  logic [1:0]          mode_i,
  output logic                led_o,
  output logic [PWM_BITS-1:0] level_o,
  output logic                peak_o
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_SOLID   = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    RAMP_UP,
    HOLD_HI,
    RAMP_DOWN,
    HOLD_LO
  } state_t;

  localparam logic [PWM_BITS-1:0] MAX    = '1;
  localparam logic [PWM_BITS:0]   MAX_X  = {1'b0, MAX};
  localparam logic [PWM_BITS:0]   STEP_X = (PWM_BITS + 1)'(STEP);
  localparam logic [PWM_BITS-1:0] STEP_N = PWM_BITS'(STEP);

  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

  // With a zero hold the ramps turn around directly at the extremes.
  localparam state_t AFTER_PEAK   = (HOLD_TICKS == 0) ? RAMP_DOWN : HOLD_HI;
  localparam state_t AFTER_TROUGH = (HOLD_TICKS == 0) ? RAMP_UP   : HOLD_LO;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic [HOLD_W-1:0]   hold_cnt;
  state_t              state;
  mode_t               mode_q;

  logic [PWM_BITS:0]   up_sum;
  logic                reach_max;
  logic                reach_zero;
  logic [PWM_BITS-1:0] up_next;
  logic [PWM_BITS-1:0] dn_next;

  // Ramp arithmetic is done one bit wider and clamped so the level never wraps.
  assign up_sum     = {1'b0, level_o} + STEP_X;
  assign reach_max  = (up_sum >= MAX_X);
  assign up_next    = reach_max ? MAX : up_sum[PWM_BITS-1:0];
  assign reach_zero = ({1'b0, level_o} <= STEP_X);
  assign dn_next    = reach_zero ? '0 : (level_o - STEP_N);

  // PWM counter, wrap-aligned duty reload and registered LED drive.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_cnt <= '0;
      duty    <= '0;
      led_o   <= 1'b0;
    end else if (en_i) begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == MAX) begin
        duty <= level_o;
      end
      case (mode_q)
        MODE_OFF:   led_o <= 1'b0;
        MODE_SOLID: led_o <= 1'b1;
        default:    led_o <= (pwm_cnt < duty);
      endcase
    end else begin
      led_o <= 1'b0;
    end
  end

  // Mode tracking, brightness level and the breathe sequencer with peak pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_o  <= '0;
      state    <= RAMP_UP;
      hold_cnt <= '0;
      mode_q   <= MODE_OFF;
      peak_o   <= 1'b0;
    end else begin
      mode_q <= mode_t'(mode_i);
      peak_o <= 1'b0;
      if (mode_t'(mode_i) != mode_q) begin
        level_o  <= '0;
        state    <= RAMP_UP;
        hold_cnt <= '0;
      end else if (en_i) begin
        case (mode_q)
          MODE_OFF: begin
            level_o <= '0;
          end
          MODE_SOLID: begin
            level_o <= MAX;
          end
          MODE_BLINK: begin
            if (tick_i) begin
              level_o <= (level_o == MAX) ? '0 : MAX;
            end
          end
          MODE_BREATHE: begin
            if (tick_i) begin
              case (state)
                RAMP_UP: begin
                  level_o <= up_next;
                  if (reach_max) begin
                    peak_o <= 1'b1;
                    state  <= AFTER_PEAK;
                  end
                end
                HOLD_HI: begin
                  if (hold_cnt == HOLD_LAST) begin
                    hold_cnt <= '0;
                    state    <= RAMP_DOWN;
                  end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                  end
                end
                RAMP_DOWN: begin
                  level_o <= dn_next;
                  if (reach_zero) begin
                    state <= AFTER_TROUGH;
                  end
                end
                HOLD_LO: begin
                  if (hold_cnt == HOLD_LAST) begin
                    hold_cnt <= '0;
                    state    <= RAMP_UP;
                  end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                  end
                end
                default: begin
                  state <= RAMP_UP;
                end
              endcase
            end
          end
          default: begin
            level_o <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_breathe.sv
// tb_led_breathe: two led_breathe instances (STEP=1/HOLD=2 and STEP=6/HOLD=0, 4-bit PWM)
// driven from shared stimulus and compared against a tick-sequence reference model.
module tb_led_breathe;

  localparam int PW     = 4;
  localparam int MAXV   = (1 << PW) - 1;
  localparam int STEP_A = 1;
  localparam int HOLD_A = 2;
  localparam int STEP_B = 6;
  localparam int HOLD_B = 0;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic          tick_i;
  logic [1:0]    mode_i;
  logic          led_a, led_b, peak_a, peak_b;
  logic [PW-1:0] level_a, level_b;

  // 25 MHz board clock.
  always #20 clk_i = ~clk_i;

  led_breathe #(.PWM_BITS(PW), .STEP(STEP_A), .HOLD_TICKS(HOLD_A)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .tick_i(tick_i), .mode_i(mode_i),
    .led_o(led_a), .level_o(level_a), .peak_o(peak_a)
  );

  led_breathe #(.PWM_BITS(PW), .STEP(STEP_B), .HOLD_TICKS(HOLD_B)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .tick_i(tick_i), .mode_i(mode_i),
    .led_o(led_b), .level_o(level_b), .peak_o(peak_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the breathe waveform is a precomputed list of per-tick levels.
  int m_cnt, m_mq;
  int m_duty[2], m_level[2], m_led[2], m_peak[2], m_pos[2];
  int seq_lv[2][64], seq_pk[2][64], seq_len[2];

  typedef struct {
    logic       en;
    logic       tick;
    logic [1:0] mode;
    int         lv_a;
    int         pk_a;
    int         lv_b;
    int         pk_b;
  } vec_t;

  vec_t tbl[18];
  int   exp_q[$];
  int   hi, pk_seen, first_led;
  int   blink_exp[3];

  function automatic void build_seq(input int k, input int step, input int hold);
    int lv = 0;
    int n = 0;
    do begin
      lv = (lv + step > MAXV) ? MAXV : lv + step;
      seq_lv[k][n] = lv; seq_pk[k][n] = (lv == MAXV) ? 1 : 0; n++;
    end while (lv != MAXV);
    for (int i = 0; i < hold; i++) begin
      seq_lv[k][n] = MAXV; seq_pk[k][n] = 0; n++;
    end
    do begin
      lv = (lv - step < 0) ? 0 : lv - step;
      seq_lv[k][n] = lv; seq_pk[k][n] = 0; n++;
    end while (lv != 0);
    for (int i = 0; i < hold; i++) begin
      seq_lv[k][n] = 0; seq_pk[k][n] = 0; n++;
    end
    seq_len[k] = n;
  endfunction

  function automatic void modelReset();
    m_cnt = 0; m_mq = 0;
    for (int k = 0; k < 2; k++) begin
      m_duty[k] = 0; m_level[k] = 0; m_led[k] = 0; m_peak[k] = 0; m_pos[k] = 0;
    end
  endfunction

  function automatic void modelClock(input logic en, input logic tick, input int mode);
    for (int k = 0; k < 2; k++) begin
      if (en) begin
        m_led[k] = (m_mq == 1) ? 1 : (m_mq == 0) ? 0 : ((m_cnt < m_duty[k]) ? 1 : 0);
        if (m_cnt == MAXV) m_duty[k] = m_level[k];
      end else begin
        m_led[k] = 0;
      end
      m_peak[k] = 0;
      if (mode != m_mq) begin
        m_level[k] = 0; m_pos[k] = 0;
      end else if (en) begin
        case (mode)
          0: m_level[k] = 0;
          1: m_level[k] = MAXV;
          2: if (tick) begin
               m_level[k] = seq_lv[k][m_pos[k]];
               m_peak[k]  = seq_pk[k][m_pos[k]];
               m_pos[k]   = (m_pos[k] + 1) % seq_len[k];
             end
          default: if (tick) m_level[k] = (m_level[k] == MAXV) ? 0 : MAXV;
        endcase
      end
    end
    if (en) m_cnt = (m_cnt + 1) % (MAXV + 1);
    m_mq = mode;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic tick, input logic [1:0] mode);
    en_i = en; tick_i = tick; mode_i = mode;
    @(posedge clk_i);
    modelClock(en, tick, int'(mode));
    #1;
    checkOutput("model_led_a",   int'(led_a),   m_led[0]);
    checkOutput("model_level_a", int'(level_a), m_level[0]);
    checkOutput("model_peak_a",  int'(peak_a),  m_peak[0]);
    checkOutput("model_led_b",   int'(led_b),   m_led[1]);
    checkOutput("model_level_b", int'(level_b), m_level[1]);
    checkOutput("model_peak_b",  int'(peak_b),  m_peak[1]);
  endtask

  task automatic doReset();
    rst_ni = 1'b0; en_i = 1'b0; tick_i = 1'b0; mode_i = 2'b00;
    modelReset();
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_led_a",   int'(led_a),   0);
    checkOutput("rst_level_a", int'(level_a), 0);
    checkOutput("rst_peak_a",  int'(peak_a),  0);
    checkOutput("rst_level_b", int'(level_b), 0);
    rst_ni = 1'b1;
  endtask

  task automatic runToWrap();
    for (int i = 0; i < 40 && m_cnt != MAXV; i++) applyStimulus(1'b1, 1'b0, 2'b10);
  endtask

  initial begin
    build_seq(0, STEP_A, HOLD_A);
    build_seq(1, STEP_B, HOLD_B);
    rst_ni = 1'b1; en_i = 1'b0; tick_i = 1'b0; mode_i = 2'b00;

    // Table-driven vectors: mode changes, saturation, enable freeze, blink, solid, off.
    tbl = '{
      '{1'b1, 1'b0, 2'b10,  0, 0,  0, 0},
      '{1'b1, 1'b1, 2'b10,  1, 0,  6, 0},
      '{1'b1, 1'b1, 2'b10,  2, 0, 12, 0},
      '{1'b1, 1'b0, 2'b10,  2, 0, 12, 0},
      '{1'b1, 1'b1, 2'b10,  3, 0, 15, 1},
      '{1'b1, 1'b1, 2'b10,  4, 0,  9, 0},
      '{1'b0, 1'b1, 2'b10,  4, 0,  9, 0},
      '{1'b1, 1'b1, 2'b10,  5, 0,  3, 0},
      '{1'b1, 1'b1, 2'b10,  6, 0,  0, 0},
      '{1'b1, 1'b1, 2'b10,  7, 0,  6, 0},
      '{1'b1, 1'b1, 2'b11,  0, 0,  0, 0},
      '{1'b1, 1'b1, 2'b11, 15, 0, 15, 0},
      '{1'b1, 1'b0, 2'b11, 15, 0, 15, 0},
      '{1'b1, 1'b1, 2'b11,  0, 0,  0, 0},
      '{1'b1, 1'b0, 2'b01,  0, 0,  0, 0},
      '{1'b1, 1'b0, 2'b01, 15, 0, 15, 0},
      '{1'b1, 1'b0, 2'b00,  0, 0,  0, 0},
      '{1'b1, 1'b1, 2'b00,  0, 0,  0, 0}
    };
    doReset();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].en, tbl[i].tick, tbl[i].mode);
      checkOutput("tbl_level_a", int'(level_a), tbl[i].lv_a);
      checkOutput("tbl_peak_a",  int'(peak_a),  tbl[i].pk_a);
      checkOutput("tbl_level_b", int'(level_b), tbl[i].lv_b);
      checkOutput("tbl_peak_b",  int'(peak_b),  tbl[i].pk_b);
    end

    // Full breathe cycle on instance A, one tick every 20 clocks.
    doReset();
    applyStimulus(1'b1, 1'b0, 2'b10);
    exp_q.delete();
    for (int v = 1; v <= MAXV; v++) exp_q.push_back(v);
    exp_q.push_back(MAXV); exp_q.push_back(MAXV);
    for (int v = MAXV - 1; v >= 0; v--) exp_q.push_back(v);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    pk_seen = 0;
    foreach (exp_q[i]) begin
      applyStimulus(1'b1, 1'b1, 2'b10);
      checkOutput("ramp_level", int'(level_a), exp_q[i]);
      pk_seen += int'(peak_a);
      if (i == MAXV - 1) checkOutput("ramp_peak_at_max", int'(peak_a), 1);
      for (int j = 0; j < 19; j++) begin
        applyStimulus(1'b1, 1'b0, 2'b10);
        pk_seen += int'(peak_a);
      end
    end
    checkOutput("ramp_peak_count", pk_seen, 1);

    // Level 5 gives 5 high clocks per 16, first high right after the wrap.
    doReset();
    applyStimulus(1'b1, 1'b0, 2'b10);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 2'b10);
    checkOutput("pwm5_level", int'(level_a), 5);
    runToWrap();
    applyStimulus(1'b1, 1'b0, 2'b10);
    hi = 0;
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b1, 1'b0, 2'b10);
      if (j == 0) first_led = int'(led_a);
      hi += int'(led_a);
    end
    checkOutput("pwm5_high_count", hi, 5);
    checkOutput("pwm5_first_clk", first_led, 1);

    // Tick on the wrap cycle: this period keeps 5, the next one uses 6.
    runToWrap();
    applyStimulus(1'b1, 1'b1, 2'b10);
    checkOutput("wrap_tick_level", int'(level_a), 6);
    hi = 0;
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b1, 1'b0, 2'b10);
      hi += int'(led_a);
    end
    checkOutput("wrap_period_old", hi, 5);
    hi = 0;
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b1, 1'b0, 2'b10);
      hi += int'(led_a);
    end
    checkOutput("wrap_period_new", hi, 6);

    // Switch breathe to blink at level 9, then blink without any peak pulse.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b10);
      applyStimulus(1'b1, 1'b0, 2'b10);
    end
    checkOutput("pre_switch_level", int'(level_a), 9);
    applyStimulus(1'b1, 1'b1, 2'b11);
    checkOutput("switch_level", int'(level_a), 0);
    blink_exp = '{MAXV, 0, MAXV};
    pk_seen = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b11);
      checkOutput("blink_level", int'(level_a), blink_exp[i]);
      pk_seen += int'(peak_a) + int'(peak_b);
      for (int j = 0; j < 3; j++) begin
        applyStimulus(1'b1, 1'b0, 2'b11);
        pk_seen += int'(peak_a) + int'(peak_b);
      end
    end
    checkOutput("blink_peak_count", pk_seen, 0);

    // Disable for 100 clocks at level 7 with ticks, then async reset while LED is high.
    doReset();
    applyStimulus(1'b1, 1'b0, 2'b10);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 2'b10);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 2'b10);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, (i % 20) == 0, 2'b10);
      hi += int'(led_a);
    end
    checkOutput("disabled_led_high", hi, 0);
    checkOutput("disabled_level", int'(level_a), 7);
    for (int i = 0; i < 40 && !led_a; i++) applyStimulus(1'b1, 1'b0, 2'b10);
    checkOutput("led_high_before_rst", int'(led_a), 1);
    #5 rst_ni = 1'b0;
    #1;
    checkOutput("async_rst_led", int'(led_a), 0);
    checkOutput("async_rst_level", int'(level_a), 0);
    modelReset();
    en_i = 1'b0; tick_i = 1'b0; mode_i = 2'b00;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Randomized traffic against the reference model.
    mode_i = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] md;
      md = mode_i;
      if ($urandom_range(0, 99) == 0) md = 2'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, md);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
